// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS fetch path: next-PC select codes,
// reset defaults and the fetch-stage state encoding.
package pipe_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JR  = 2'd2;
    localparam logic [1:0] PCSRC_J   = 2'd3;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pipe_ir_reg.sv
// IF/ID pipeline register bank. A bubble load inserts a nop and clears valid
// while keeping the previous pc4 for debug.
module pipe_ir_reg
    import pipe_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            en,
    input  logic            bubble,
    input  logic [31:0]     inst,
    input  logic [PC_W-1:0] pc4,
    output logic [31:0]     id_inst,
    output logic [PC_W-1:0] id_pc4,
    output logic            id_valid
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            id_inst  <= NOP_INST;
            id_pc4   <= '0;
            id_valid <= 1'b0;
        end else if (en) begin
            if (bubble) begin
                id_inst  <= NOP_INST;
                id_valid <= 1'b0;
            end else begin
                id_inst  <= inst;
                id_pc4   <= pc4;
                id_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, RUN/HALT control for
// misaligned targets, and the IF/ID register feeding decode.
module pipe_if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            wpcir,
    input  logic [1:0]      pcsrc,
    input  logic [PC_W-1:0] bpc,
    input  logic [PC_W-1:0] rpc,
    input  logic [PC_W-1:0] jpc,
    input  logic [31:0]     imem_data,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     id_inst,
    output logic [PC_W-1:0] id_pc4,
    output logic            id_valid,
    output logic            fetch_err,
    output logic [31:0]     fetch_count
);

    fetch_state_t    state, next_state;
    logic [PC_W-1:0] pc4;
    logic [PC_W-1:0] npc;
    logic            misaligned;
    logic            pc_en;
    logic            ir_en;
    logic            bubble;
    logic            cnt_en;

    assign imem_addr = pc;
    assign pc4       = pc + PC_W'(4);

    always_comb begin
        unique case (pcsrc)
            PCSRC_SEQ: npc = pc4;
            PCSRC_BR:  npc = bpc;
            PCSRC_JR:  npc = rpc;
            default:   npc = jpc;
        endcase
    end

    assign misaligned = (npc[1:0] != 2'b00);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        bubble     = 1'b0;
        cnt_en     = 1'b0;
        unique case (state)
            RUN: begin
                if (wpcir) begin
                    pc_en = 1'b1;
                    ir_en = 1'b1;
                    if (misaligned) begin
                        bubble     = 1'b1;
                        next_state = HALT;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            HALT: ;
            default: next_state = RUN;
        endcase
    end

    // NOTE: control registers all clear asynchronously on clrn so a reset
    // mid-stall or mid-redirect lands in a known state immediately.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= RUN;
            pc          <= RESET_PC[PC_W-1:0];
            fetch_count <= '0;
        end else begin
            state <= next_state;
            if (pc_en)
                pc <= npc;
            if (cnt_en)
                fetch_count <= fetch_count + 32'd1;
        end
    end

    assign fetch_err = (state == HALT);

    pipe_ir_reg #(
        .PC_W (PC_W)
    ) u_ir_reg (
        .clk      (clk),
        .clrn     (clrn),
        .en       (ir_en),
        .bubble   (bubble),
        .inst     (imem_data),
        .pc4      (pc4),
        .id_inst  (id_inst),
        .id_pc4   (id_pc4),
        .id_valid (id_valid)
    );

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed bench for pipe_if_stage: sequential fetch, stall, branch/jump
// delay slots, PC wrap, misalignment halt and asynchronous reset out of HALT.
module tb_pipe_if_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        wpcir;
    logic [1:0]  pcsrc;
    logic [31:0] bpc, rpc, jpc;
    logic [31:0] imem_data;
    logic [31:0] imem_addr, pc, id_inst, id_pc4, fetch_count;
    logic        id_valid, fetch_err;
    logic        imem_x;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    assign imem_data = imem_x ? 32'hxxxx_xxxx : word(imem_addr);

    pipe_if_stage dut (
        .clk         (clk),
        .clrn        (clrn),
        .wpcir       (wpcir),
        .pcsrc       (pcsrc),
        .bpc         (bpc),
        .rpc         (rpc),
        .jpc         (jpc),
        .imem_data   (imem_data),
        .imem_addr   (imem_addr),
        .pc          (pc),
        .id_inst     (id_inst),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .fetch_err   (fetch_err),
        .fetch_count (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic w, input logic [1:0] src);
        wpcir = w;
        pcsrc = src;
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_inst, input logic [31:0] e_pc4,
                               input logic [31:0] e_cnt);
        check({tag, ".pc"},    pc,          e_pc);
        check({tag, ".addr"},  imem_addr,   e_pc);
        check({tag, ".inst"},  id_inst,     e_inst);
        check({tag, ".pc4"},   id_pc4,      e_pc4);
        check({tag, ".valid"}, 32'(id_valid), 32'd1);
        check({tag, ".cnt"},   fetch_count, e_cnt);
    endtask

    task automatic check_halt(input string tag, input logic [31:0] e_pc, input logic [31:0] e_cnt);
        check({tag, ".pc"},    pc,           e_pc);
        check({tag, ".inst"},  id_inst,      32'h0);
        check({tag, ".valid"}, 32'(id_valid), 32'd0);
        check({tag, ".err"},   32'(fetch_err), 32'd1);
        check({tag, ".cnt"},   fetch_count,  e_cnt);
    endtask

    initial begin
        clrn = 1'b0; wpcir = 1'b0; pcsrc = 2'd0; imem_x = 1'b0;
        bpc = '0; rpc = '0; jpc = '0;
        #12;
        check("rst.pc",    pc,           32'h0);
        check("rst.inst",  id_inst,      32'h0);
        check("rst.pc4",   id_pc4,       32'h0);
        check("rst.valid", 32'(id_valid), 32'd0);
        check("rst.err",   32'(fetch_err), 32'd0);
        check("rst.cnt",   fetch_count,  32'h0);
        clrn = 1'b1;

        // Sequential fetch with one-edge lag on id_inst
        for (int k = 1; k <= 4; k++) begin
            tick(1'b1, 2'd0);
            check_fetch($sformatf("seq%0d", k), 32'(4 * k), word(32'(4 * (k - 1))), 32'(4 * k), 32'(k));
        end

        // Reach 0x74 via jr, then a load-use stall with X on imem
        rpc = 32'h74; tick(1'b1, 2'd2);
        check_fetch("jr74", 32'h74, word(32'h10), 32'h14, 32'd5);
        imem_x = 1'b1; tick(1'b0, 2'd1);
        check_fetch("stall", 32'h74, word(32'h10), 32'h14, 32'd5);
        imem_x = 1'b0; tick(1'b1, 2'd0);
        check_fetch("after_stall", 32'h78, word(32'h74), 32'h78, 32'd6);

        // A stalled cycle with a misaligned jr target has no effect
        rpc = 32'h12; tick(1'b0, 2'd2);
        check("stall_mis.pc",  pc, 32'h78);
        check("stall_mis.err", 32'(fetch_err), 32'd0);

        // beq at 0x40 taken to 0x50 with delay slot 0x44
        rpc = 32'h40; tick(1'b1, 2'd2);
        check_fetch("to40", 32'h40, word(32'h78), 32'h7C, 32'd7);
        tick(1'b1, 2'd0);
        check_fetch("beq", 32'h44, word(32'h40), 32'h44, 32'd8);
        bpc = 32'h50; tick(1'b1, 2'd1);
        check_fetch("beq_slot", 32'h50, word(32'h44), 32'h48, 32'd9);
        tick(1'b1, 2'd0);
        check_fetch("beq_tgt", 32'h54, word(32'h50), 32'h54, 32'd10);

        // j 0x08000008 at 0x48, delay slot 0x4C, target 0x20
        rpc = 32'h48; tick(1'b1, 2'd2);
        tick(1'b1, 2'd0);
        check_fetch("j", 32'h4C, word(32'h48), 32'h4C, 32'd12);
        jpc = {4'h0, 26'h000_0008, 2'b00}; tick(1'b1, 2'd3);
        check_fetch("j_slot", 32'h20, word(32'h4C), 32'h50, 32'd13);
        tick(1'b1, 2'd0);
        jpc = {4'h0, 26'h000_001b, 2'b00}; tick(1'b1, 2'd3);
        check_fetch("jal", 32'h6C, word(32'h24), 32'h28, 32'd15);
        rpc = 32'h10; tick(1'b1, 2'd2);
        check_fetch("jr10", 32'h10, word(32'h6C), 32'h70, 32'd16);

        // pc + 4 wraps at the top of the address space
        rpc = 32'hFFFF_FFFC; tick(1'b1, 2'd2);
        tick(1'b1, 2'd0);
        check_fetch("wrap", 32'h0, word(32'hFFFF_FFFC), 32'h0, 32'd18);

        // Misaligned jr target halts fetch
        rpc = 32'h12; tick(1'b1, 2'd2);
        check_halt("mis", 32'h12, 32'd18);
        for (int i = 0; i < 10; i++) begin
            bpc = 32'h100 + 32'(i * 4); jpc = 32'h200; rpc = 32'h300;
            tick(i % 3 != 0, 2'(i % 4));
            check_halt($sformatf("halt%0d", i), 32'h12, 32'd18);
        end

        // Fresh run to fetch_count 7, halt, then async reset mid-cycle
        clrn = 1'b0; #1 clrn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 7; k++) tick(1'b1, 2'd0);
        check_fetch("run7", 32'h1C, word(32'h18), 32'h1C, 32'd7);
        bpc = 32'h33; tick(1'b1, 2'd1);
        check_halt("mis2", 32'h33, 32'd7);
        #2 clrn = 1'b0;
        #1;
        check("arst.pc",    pc,            32'h0);
        check("arst.err",   32'(fetch_err), 32'd0);
        check("arst.cnt",   fetch_count,   32'h0);
        check("arst.valid", 32'(id_valid),  32'd0);
        #2 clrn = 1'b1;
        tick(1'b1, 2'd0);
        check_fetch("restart", 32'h4, word(32'h0), 32'h4, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
